// File: rtl/halfband_interp_2x_core.sv
// Stereo 2x halfband interpolator; sequences six MACs per channel on external DSP48A1 slices.
// Build option HALFBAND_ROUND_EN: round-half-up via the C port on the first MAC, else floor truncation.
module halfband_interp_2x_core #(
  parameter int DSP_LATENCY = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_in_rdy,
  input  logic signed [17:0] sample_in_l,
  input  logic signed [17:0] sample_in_r,
  output logic               sample_out_rdy,
  output logic signed [17:0] sample_out_l,
  output logic signed [17:0] sample_out_r,
  output logic               done,
  output logic [91:0]        dsp_ins_flat_l,
  output logic [91:0]        dsp_ins_flat_r,
  input  logic [47:0]        dsp_outs_flat_l,
  input  logic [47:0]        dsp_outs_flat_r
);

  typedef enum logic [2:0] {IDLE, MAC, WAIT, OUT0, OUT1} state_t;

`ifdef HALFBAND_ROUND_EN
  localparam logic [7:0]  K0_OPMODE = 8'h0D;
  localparam logic [47:0] K0_C      = 48'd65536;
`else
  localparam logic [7:0]  K0_OPMODE = 8'h01;
  localparam logic [47:0] K0_C      = 48'd0;
`endif

  state_t             state_q;
  logic [2:0]         k_q;
  logic [7:0]         w_q;
  logic signed [17:0] xl_q [6];
  logic signed [17:0] xr_q [6];
  logic signed [17:0] out_l_q, out_r_q;
  logic               out_rdy_q, done_q;
  logic [91:0]        dsp_l_q, dsp_r_q;

  function automatic logic signed [17:0] coef(input logic [2:0] k);
    case (k)
      3'd0, 3'd5: coef = 18'sd3000;
      3'd1, 3'd4: coef = -18'sd15000;
      default:    coef = 18'sd77536;
    endcase
  endfunction

  // First op starts a fresh accumulation (Z=0 or Z=C); the rest accumulate onto P.
  function automatic logic [91:0] mk_op(input logic [2:0] k, input logic signed [17:0] x);
    if (k == 3'd0) mk_op = {K0_OPMODE, coef(k), x, K0_C};
    else           mk_op = {8'h09, coef(k), x, 48'd0};
  endfunction

  function automatic logic signed [17:0] sat18(input logic [47:0] p);
    logic signed [47:0] s;
    s = $signed(p) >>> 17;
    if (s > 48'sd131071)       sat18 = 18'sd131071;
    else if (s < -48'sd131072) sat18 = -18'sd131072;
    else                       sat18 = s[17:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      w_q       <= '0;
      out_l_q   <= '0;
      out_r_q   <= '0;
      out_rdy_q <= 1'b0;
      done_q    <= 1'b0;
      dsp_l_q   <= '0;
      dsp_r_q   <= '0;
      for (int i = 0; i < 6; i++) begin
        xl_q[i] <= '0;
        xr_q[i] <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          out_rdy_q <= 1'b0;
          done_q    <= 1'b0;
          if (sample_in_rdy) begin
            for (int i = 5; i > 0; i--) begin
              xl_q[i] <= xl_q[i-1];
              xr_q[i] <= xr_q[i-1];
            end
            xl_q[0] <= sample_in_l;
            xr_q[0] <= sample_in_r;
            // x[n] is not in the delay line yet, so tap 0 reads the input bus directly.
            dsp_l_q <= mk_op(3'd0, sample_in_l);
            dsp_r_q <= mk_op(3'd0, sample_in_r);
            k_q     <= 3'd1;
            state_q <= MAC;
          end
        end
        MAC: begin
          if (k_q == 3'd6) begin
            dsp_l_q <= '0;
            dsp_r_q <= '0;
            w_q     <= '0;
            state_q <= WAIT;
          end else begin
            dsp_l_q <= mk_op(k_q, xl_q[k_q]);
            dsp_r_q <= mk_op(k_q, xr_q[k_q]);
            k_q     <= k_q + 3'd1;
          end
        end
        WAIT: begin
          if (w_q == 8'(DSP_LATENCY - 1)) begin
            out_l_q   <= sat18(dsp_outs_flat_l);
            out_r_q   <= sat18(dsp_outs_flat_r);
            out_rdy_q <= 1'b1;
            state_q   <= OUT0;
          end else begin
            w_q <= w_q + 8'd1;
          end
        end
        OUT0: begin
          out_l_q   <= xl_q[2];
          out_r_q   <= xr_q[2];
          out_rdy_q <= 1'b1;
          done_q    <= 1'b1;
          state_q   <= OUT1;
        end
        OUT1: begin
          out_rdy_q <= 1'b0;
          done_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sample_out_rdy = out_rdy_q;
  assign sample_out_l   = out_l_q;
  assign sample_out_r   = out_r_q;
  assign done           = done_q;
  assign dsp_ins_flat_l = dsp_l_q;
  assign dsp_ins_flat_r = dsp_r_q;

endmodule

// File: tb/tb_halfband_interp_2x_core.sv
// Bench for halfband_interp_2x_core: behavioural DSP slices, reference FIR model and output scoreboard.
module tb_halfband_interp_2x_core;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               sample_in_rdy = 1'b0;
  logic signed [17:0] sample_in_l = '0;
  logic signed [17:0] sample_in_r = '0;
  logic               sample_out_rdy;
  logic signed [17:0] sample_out_l, sample_out_r;
  logic               done;
  logic [91:0]        dsp_ins_flat_l, dsp_ins_flat_r;
  logic [47:0]        dsp_outs_flat_l, dsp_outs_flat_r;

  int n_chk = 0;
  int n_fail = 0;

  halfband_interp_2x_core #(.DSP_LATENCY(3)) dut (
    .clk(clk), .reset(reset),
    .sample_in_rdy(sample_in_rdy), .sample_in_l(sample_in_l), .sample_in_r(sample_in_r),
    .sample_out_rdy(sample_out_rdy), .sample_out_l(sample_out_l), .sample_out_r(sample_out_r),
    .done(done),
    .dsp_ins_flat_l(dsp_ins_flat_l), .dsp_ins_flat_r(dsp_ins_flat_r),
    .dsp_outs_flat_l(dsp_outs_flat_l), .dsp_outs_flat_r(dsp_outs_flat_r)
  );

  always #5 clk = ~clk;

  // Behavioural DSP48A1: two request stages then the P register, i.e. 3 cycles request->P.
  logic [91:0]        rl1 = '0, rl2 = '0, rr1 = '0, rr2 = '0;
  logic signed [47:0] pl = '0, pr = '0;

  function automatic logic signed [47:0] dsp_calc(input logic [91:0] req, input logic signed [47:0] p);
    logic [7:0]         op;
    logic signed [17:0] a, b;
    logic signed [47:0] c, m, x, z;
    op = req[91:84];
    a  = req[83:66];
    b  = req[65:48];
    c  = req[47:0];
    m  = a * b;
    x  = (op[1:0] == 2'b01) ? m : 48'sd0;
    case (op[3:2])
      2'b10:   z = p;
      2'b11:   z = c;
      default: z = 48'sd0;
    endcase
    return x + z;
  endfunction

  always @(posedge clk) begin
    rl1 <= dsp_ins_flat_l; rl2 <= rl1; pl <= dsp_calc(rl2, pl);
    rr1 <= dsp_ins_flat_r; rr2 <= rr1; pr <= dsp_calc(rr2, pr);
  end
  assign dsp_outs_flat_l = pl;
  assign dsp_outs_flat_r = pr;

  // Reference model and scoreboard.
  typedef struct { int l; int r; bit odd; } exp_t;
  exp_t sb[$];
  int ml[6];
  int mr[6];
  int coef_t[6] = '{3000, -15000, 77536, 77536, -15000, 3000};

  function automatic int ref_even(input int x[6]);
    longint acc = 0;
    for (int k = 0; k < 6; k++) acc += longint'(coef_t[k]) * longint'(x[k]);
`ifdef HALFBAND_ROUND_EN
    acc += 65536;
`endif
    acc = acc >>> 17;
    if (acc > 131071) acc = 131071;
    if (acc < -131072) acc = -131072;
    return int'(acc);
  endfunction

  function automatic void model_push(input int l, input int r);
    exp_t e;
    for (int i = 5; i > 0; i--) begin
      ml[i] = ml[i-1];
      mr[i] = mr[i-1];
    end
    ml[0] = l;
    mr[0] = r;
    e.l = ref_even(ml); e.r = ref_even(mr); e.odd = 1'b0;
    sb.push_back(e);
    e.l = ml[2]; e.r = mr[2]; e.odd = 1'b1;
    sb.push_back(e);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 6; i++) begin
      ml[i] = 0;
      mr[i] = 0;
    end
    sb.delete();
  endfunction

  int last_even_l, last_even_r, last_odd_l, last_odd_r;

  always @(negedge clk) begin
    if (!reset && sample_out_rdy === 1'b1) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output got l=%0d r=%0d required no output", sample_out_l, sample_out_r);
      end else begin
        exp_t e;
        int al, ar;
        e  = sb.pop_front();
        al = int'(sample_out_l);
        ar = int'(sample_out_r);
        if (al !== e.l || ar !== e.r) begin
          n_fail++;
          $display("FAIL sb_%s got l=%0d r=%0d required l=%0d r=%0d", e.odd ? "odd" : "even", al, ar, e.l, e.r);
        end
        if (e.odd) begin last_odd_l = al; last_odd_r = ar; end
        else       begin last_even_l = al; last_even_r = ar; end
      end
    end
  end

  // Strobe one sample and wait (bounded) for done, leaving the DUT back in IDLE.
  task automatic send(input int l, input int r);
    bit got = 0;
    sample_in_l = 18'(l);
    sample_in_r = 18'(r);
    sample_in_rdy = 1'b1;
    model_push(l, r);
    @(negedge clk);
    sample_in_rdy = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (done === 1'b1) got = 1;
      else @(negedge clk);
    end
    n_chk++;
    if (!got) begin
      n_fail++;
      $display("FAIL done_timeout got=0 required=1");
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    n_chk++;
    if (sample_out_rdy !== 1'b0 || done !== 1'b0 || sample_out_l !== 18'd0 || sample_out_r !== 18'd0
        || dsp_ins_flat_l !== 92'd0 || dsp_ins_flat_r !== 92'd0) begin
      n_fail++;
      $display("FAIL reset_state got rdy=%b done=%b l=%0d r=%0d required all zero",
               sample_out_rdy, done, sample_out_l, sample_out_r);
    end
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_impulse();
`ifdef HALFBAND_ROUND_EN
    int even_t[6] = '{23, -114, 592, 592, -114, 23};
`else
    int even_t[6] = '{22, -115, 591, 591, -115, 22};
`endif
    for (int i = 0; i < 6; i++) begin
      send(i == 0 ? 1000 : 0, 0);
      n_chk++;
      if (last_even_l !== even_t[i] || last_odd_l !== (i == 2 ? 1000 : 0)
          || last_even_r !== 0 || last_odd_r !== 0) begin
        n_fail++;
        $display("FAIL impulse_%0d got even_l=%0d odd_l=%0d even_r=%0d odd_r=%0d required %0d %0d 0 0",
                 i, last_even_l, last_odd_l, last_even_r, last_odd_r, even_t[i], (i == 2 ? 1000 : 0));
      end
    end
  endtask

  task automatic test_timing();
    logic [7:0] op_l, op_r, op_exp;
    sample_in_l = 18'sd1234;
    sample_in_r = -18'sd4321;
    sample_in_rdy = 1'b1;
    model_push(1234, -4321);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      sample_in_rdy = 1'b0;
      op_l = dsp_ins_flat_l[91:84];
      op_r = dsp_ins_flat_r[91:84];
`ifdef HALFBAND_ROUND_EN
      op_exp = (c == 1) ? 8'h0D : (c <= 6) ? 8'h09 : 8'h00;
`else
      op_exp = (c == 1) ? 8'h01 : (c <= 6) ? 8'h09 : 8'h00;
`endif
      n_chk++;
      if (op_l !== op_exp || op_r !== op_exp) begin
        n_fail++;
        $display("FAIL opmode_c%0d got l=%h r=%h required %h", c, op_l, op_r, op_exp);
      end
      if (c > 6) begin
        n_chk++;
        if (dsp_ins_flat_l !== 92'd0 || dsp_ins_flat_r !== 92'd0) begin
          n_fail++;
          $display("FAIL dsp_idle_c%0d got l=%h r=%h required 0", c, dsp_ins_flat_l, dsp_ins_flat_r);
        end
      end
      n_chk++;
      if (sample_out_rdy !== (c == 10 || c == 11) || done !== (c == 11)) begin
        n_fail++;
        $display("FAIL strobe_c%0d got rdy=%b done=%b required rdy=%b done=%b",
                 c, sample_out_rdy, done, (c == 10 || c == 11), (c == 11));
      end
    end
  endtask

  task automatic test_dc();
    for (int i = 0; i < 8; i++) begin
      send(5000, -7000);
      if (i >= 5) begin
        n_chk++;
        if (last_even_l !== 5000 || last_odd_l !== 5000 || last_even_r !== -7000 || last_odd_r !== -7000) begin
          n_fail++;
          $display("FAIL dc_%0d got l=%0d/%0d r=%0d/%0d required 5000/5000 -7000/-7000",
                   i, last_even_l, last_odd_l, last_even_r, last_odd_r);
        end
      end
    end
  endtask

  task automatic test_saturation();
    int pat[6] = '{131071, -131072, 131071, 131071, -131072, 131071};
    for (int i = 0; i < 6; i++) send(pat[i], (pat[i] == 131071) ? -131072 : 131071);
    n_chk++;
    if (last_even_l !== 131071 || last_even_r !== -131072) begin
      n_fail++;
      $display("FAIL saturation got l=%0d r=%0d required 131071 -131072", last_even_l, last_even_r);
    end
  endtask

  task automatic test_busy();
    int rdy_cnt = 0;
    int done_cnt = 0;
    sample_in_l = 18'sd2500;
    sample_in_r = 18'sd300;
    sample_in_rdy = 1'b1;
    model_push(2500, 300);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (c == 5) begin
        sample_in_l = 18'sd777;
        sample_in_r = -18'sd777;
      end
      sample_in_rdy = (c == 5);
      if (sample_out_rdy === 1'b1) rdy_cnt++;
      if (done === 1'b1) done_cnt++;
    end
    n_chk++;
    if (rdy_cnt != 2 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL busy_pulses got rdy=%0d done=%0d required rdy=2 done=1", rdy_cnt, done_cnt);
    end
    send(-900, 4100);
    send(0, 0);
  endtask

  task automatic test_reset_mid_mac();
    bit bad = 0;
    sample_in_l = 18'sd4000;
    sample_in_r = 18'sd4000;
    sample_in_rdy = 1'b1;
    @(negedge clk);
    sample_in_rdy = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_chk++;
    if (dsp_ins_flat_l !== 92'd0 || dsp_ins_flat_r !== 92'd0 || sample_out_rdy !== 1'b0 || done !== 1'b0
        || sample_out_l !== 18'd0 || sample_out_r !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_mid_mac got dsp_l=%h rdy=%b out_l=%0d required all zero",
               dsp_ins_flat_l, sample_out_rdy, sample_out_l);
    end
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (dsp_ins_flat_l !== 92'd0 || dsp_ins_flat_r !== 92'd0 || sample_out_rdy !== 1'b0) bad = 1;
    end
    n_chk++;
    if (bad) begin
      n_fail++;
      $display("FAIL post_reset_idle got nonzero request or strobe required zero");
    end
    // Delay line must have been cleared: an impulse now sees zero history.
    send(1000, 1000);
    send(0, 0);
    send(0, 0);
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_timing();
    test_dc();
    test_saturation();
    test_busy();
    test_reset_mid_mac();
    repeat (4) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
